ahb_slave_ctrl: RTL and testbench

- AHB-Lite slave-side sequencer between the AHB slave port (sel/addr/write/wdata/rdata/ready/slave_error) and a simple req/ack backend (register file or SRAM wrapper).
- Accepts address phases and generates byte strobes from size/addr.
- Inserts wait states until the backend acks.
- Produces the two-cycle ERROR response for misaligned transfers, backend errors and backend timeouts.
- Sits inside each AHB slave instance, in front of its storage.

---
 rtl/ahb_slave_ctrl.sv | 128 ++++++++++++
 tb/tb_ahb_slave_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_slave_ctrl.sv
// AHB-Lite slave-side sequencer: captures the address phase, builds byte
// strobes, stalls the bus until the req/ack backend completes, and returns
// the two-cycle ERROR response on misalignment, backend error or timeout.
module ahb_slave_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    sel,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [1:0]              trans,
    input  logic                    write,
    input  logic [2:0]              size,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic                    ready_in,
    output logic                    ready,
    output logic                    slave_error,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    bk_req,
    output logic                    bk_write,
    output logic [ADDR_WIDTH-1:0]   bk_addr,
    output logic [DATA_WIDTH-1:0]   bk_wdata,
    output logic [DATA_WIDTH/8-1:0] bk_strb,
    input  logic                    bk_ack,
    input  logic [DATA_WIDTH-1:0]   bk_rdata,
    input  logic                    bk_err,
    output logic [7:0]              err_cnt
);
    localparam int NB   = DATA_WIDTH / 8;
    localparam int OFFW = $clog2(NB);
    localparam int CW   = $clog2(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_ERR1, S_ERR2} state_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic                  write;
        logic [NB-1:0]         strb;
    } req_t;

    state_t        state;
    req_t          req_q;
    logic [CW-1:0] wcnt;

    logic            accept;
    logic            misaligned;
    logic [7:0]      span_m1;
    logic [OFFW-1:0] offset;
    logic [NB-1:0]   strb_c;
    logic            htrans_active;

    // Byte lane span and alignment of the incoming address phase
    always_comb begin
        span_m1    = 8'((9'd1 << size) - 9'd1);
        offset     = addr[OFFW-1:0];
        misaligned = (size > 3'(OFFW)) || ((offset & span_m1[OFFW-1:0]) != '0);
        strb_c     = '0;
        for (int b = 0; b < NB; b++)
            strb_c[b] = (b >= int'(offset)) && (b <= int'(offset) + int'(span_m1));
    end

    // Bus-side response decoded from the state; ACCESS completes on a clean ack
    always_comb begin
        ready       = 1'b1;
        slave_error = 1'b0;
        rdata       = '0;
        case (state)
            S_ACCESS: begin
                ready = bk_ack & ~bk_err;
                if (bk_ack && !req_q.write) rdata = bk_rdata;
            end
            S_ERR1: begin
                ready       = 1'b0;
                slave_error = 1'b1;
            end
            S_ERR2: slave_error = 1'b1;
            default: ;
        endcase
        htrans_active = (trans == 2'b10) || (trans == 2'b11);
        accept        = sel & ready_in & htrans_active & ready;
    end

    assign bk_req   = (state == S_ACCESS);
    assign bk_write = req_q.write;
    assign bk_addr  = req_q.addr;
    assign bk_strb  = req_q.strb;
    assign bk_wdata = (state == S_ACCESS) ? wdata : '0;

    // Transfer sequencing, wait counter and saturating error counter
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= S_IDLE;
            req_q   <= '0;
            wcnt    <= '0;
            err_cnt <= '0;
        end else begin
            if (state == S_ERR2 && err_cnt != 8'hFF)
                err_cnt <= err_cnt + 8'd1;

            case (state)
                S_ACCESS: begin
                    if (bk_ack && bk_err)
                        state <= S_ERR1;
                    else if (bk_ack)
                        state <= S_IDLE;
                    else if (wcnt == CW'(TIMEOUT - 1))
                        state <= S_ERR1;   // late acks land in ERR1 and are ignored
                    else
                        wcnt <= wcnt + 1'b1;
                end
                S_ERR1:  state <= S_ERR2;
                S_ERR2:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase

            // A new address phase overrides the completion transition above
            if (accept) begin
                req_q.addr  <= addr;
                req_q.write <= write;
                req_q.strb  <= strb_c;
                wcnt        <= '0;
                state       <= misaligned ? S_ERR1 : S_ACCESS;
            end
        end
    end
endmodule

// File: tb/tb_ahb_slave_ctrl.sv
// Directed bench for ahb_slave_ctrl with a transaction-level reference model
// and a per-cycle comparison of all bus and backend outputs.
module tb_ahb_slave_ctrl;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;
    localparam int NB = DW / 8;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          sel = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [1:0]    trans = 2'b00;
    logic          write = 1'b0;
    logic [2:0]    size = 3'd0;
    logic [DW-1:0] wdata = '0;
    logic          ready_in = 1'b1;
    logic          ready, slave_error;
    logic [DW-1:0] rdata;
    logic          bk_req, bk_write;
    logic [AW-1:0] bk_addr;
    logic [DW-1:0] bk_wdata;
    logic [NB-1:0] bk_strb;
    logic          bk_ack = 1'b0;
    logic [DW-1:0] bk_rdata = '0;
    logic          bk_err = 1'b0;
    logic [7:0]    err_cnt;

    always #5 clk = ~clk;

    ahb_slave_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rstn(rstn), .sel(sel), .addr(addr), .trans(trans),
        .write(write), .size(size), .wdata(wdata), .ready_in(ready_in),
        .ready(ready), .slave_error(slave_error), .rdata(rdata),
        .bk_req(bk_req), .bk_write(bk_write), .bk_addr(bk_addr),
        .bk_wdata(bk_wdata), .bk_strb(bk_strb), .bk_ack(bk_ack),
        .bk_rdata(bk_rdata), .bk_err(bk_err), .err_cnt(err_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one outstanding data phase, either held at the
    // backend (m_acc) or in its error response (m_err_left cycles to go).
    bit            m_acc;
    int            m_wait;
    int            m_err_left;
    logic [AW-1:0] m_addr;
    bit            m_write;
    logic [NB-1:0] m_strb;
    int            m_errcnt;

    function automatic bit exp_ready();
        if (m_acc) return bk_ack & ~bk_err;
        if (m_err_left == 2) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_acc = 0; m_wait = 0; m_err_left = 0; m_errcnt = 0;
            m_addr = '0; m_write = 0; m_strb = '0;
        end else begin
            bit take;
            int nb;
            int off;
            take = sel && ready_in && trans[1] && exp_ready();
            if (m_err_left == 1) begin
                if (m_errcnt < 255) m_errcnt++;
                m_err_left = 0;
            end else if (m_err_left == 2) begin
                m_err_left = 1;
            end
            if (m_acc) begin
                if (bk_ack) begin
                    m_acc = 0;
                    if (bk_err) m_err_left = 2;
                end else if (m_wait == TO - 1) begin
                    m_acc = 0;
                    m_err_left = 2;
                end else begin
                    m_wait++;
                end
            end
            if (take) begin
                nb      = 1 << size;
                m_addr  = addr;
                m_write = write;
                if (nb > NB || (addr % nb) != 0) begin
                    m_err_left = 2;
                end else begin
                    off    = int'(addr % NB);
                    m_strb = NB'(((1 << nb) - 1) << off);
                    m_acc  = 1;
                    m_wait = 0;
                end
            end
        end
    end

    // Bench-side observation counters used by the literal checks
    int            req_cycles, ready_low, serr_cycles;
    logic [NB-1:0] last_strb;
    logic [DW-1:0] last_rdata;
    logic [AW-1:0] addr_log [4];

    task automatic clr_mon();
        req_cycles = 0; ready_low = 0; serr_cycles = 0;
        last_strb = '0; last_rdata = '0;
        for (int i = 0; i < 4; i++) addr_log[i] = '1;
    endtask

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        check("ready", ready, exp_ready());
        check("slave_error", slave_error, (!m_acc && m_err_left != 0));
        check("rdata", rdata, (m_acc && bk_ack && !m_write) ? bk_rdata : '0);
        check("bk_req", bk_req, m_acc);
        check("err_cnt", err_cnt, m_errcnt);
        if (m_acc) begin
            check("bk_addr", bk_addr, m_addr);
            check("bk_write", bk_write, m_write);
            check("bk_strb", bk_strb, m_strb);
            check("bk_wdata", bk_wdata, wdata);
        end
        if (bk_req) begin
            if (req_cycles < 4) addr_log[req_cycles] = bk_addr;
            req_cycles++;
            last_strb = bk_strb;
            if (ready) last_rdata = rdata;
        end
        if (!ready) ready_low++;
        if (slave_error) serr_cycles++;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic addr_ph(logic [AW-1:0] a, logic w, logic [2:0] sz);
        sel = 1'b1; trans = 2'b10; addr = a; write = w; size = sz;
    endtask

    task automatic bus_idle();
        sel = 1'b0; trans = 2'b00;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clr_mon();
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", ready, 1'b1);
        check("rst_serr", slave_error, 1'b0);
        check("rst_bk_req", bk_req, 1'b0);
        check("rst_bk_addr", bk_addr, 32'h0);
        check("rst_bk_strb", bk_strb, 4'h0);
        check("rst_err_cnt", err_cnt, 8'h0);
        rstn = 1'b1;
        cyc();

        // Zero-wait word write
        clr_mon();
        addr_ph(32'h1000, 1'b1, 3'd2); cyc();
        bus_idle(); wdata = 32'hDEADBEEF; bk_ack = 1'b1; cyc();
        bk_ack = 1'b0; cyc();
        check("t1_req_cycles", req_cycles, 1);
        check("t1_ready_low", ready_low, 0);
        check("t1_strb", last_strb, 4'hF);
        check("t1_serr", serr_cycles, 0);

        // Halfword read with three wait states
        clr_mon();
        addr_ph(32'h1002, 1'b0, 3'd1); cyc();
        bus_idle(); repeat (3) cyc();
        bk_ack = 1'b1; bk_rdata = 32'h12345678; cyc();
        bk_ack = 1'b0; bk_rdata = '0; cyc();
        check("t2_req_cycles", req_cycles, 4);
        check("t2_ready_low", ready_low, 3);
        check("t2_strb", last_strb, 4'hC);
        check("t2_rdata", last_rdata, 32'h12345678);

        // Back-to-back pipelined writes
        clr_mon();
        addr_ph(32'h0, 1'b1, 3'd2); cyc();
        addr_ph(32'h4, 1'b1, 3'd2); wdata = 32'h1; bk_ack = 1'b1; cyc();
        bus_idle(); wdata = 32'h2; cyc();
        bk_ack = 1'b0; cyc();
        check("t3_req_cycles", req_cycles, 2);
        check("t3_ready_low", ready_low, 0);
        check("t3_addr0", addr_log[0], 32'h0);
        check("t3_addr1", addr_log[1], 32'h4);

        // Misaligned word
        clr_mon();
        addr_ph(32'h1001, 1'b0, 3'd2); cyc();
        bus_idle(); repeat (3) cyc();
        check("t4_req_cycles", req_cycles, 0);
        check("t4_ready_low", ready_low, 1);
        check("t4_serr", serr_cycles, 2);
        check("t4_err_cnt", err_cnt, 8'd1);

        // Byte write at top lane, then an oversized doubleword
        clr_mon();
        addr_ph(32'h1003, 1'b1, 3'd0); cyc();
        bus_idle(); wdata = 32'hAA000000; bk_ack = 1'b1; cyc();
        bk_ack = 1'b0; cyc();
        check("t5_strb", last_strb, 4'h8);
        addr_ph(32'h0, 1'b0, 3'd3); cyc();
        bus_idle(); repeat (3) cyc();
        check("t5_req_cycles", req_cycles, 1);
        check("t5_err_cnt", err_cnt, 8'd2);

        // Backend error on ack
        clr_mon();
        addr_ph(32'h40, 1'b0, 3'd2); cyc();
        bus_idle(); bk_ack = 1'b1; bk_err = 1'b1; cyc();
        bk_ack = 1'b0; bk_err = 1'b0; repeat (3) cyc();
        check("t6_serr", serr_cycles, 2);
        check("t6_err_cnt", err_cnt, 8'd3);

        // Backend timeout with a late ack during ERR1
        clr_mon();
        addr_ph(32'h2000, 1'b0, 3'd2); cyc();
        bus_idle(); repeat (TO) cyc();
        bk_ack = 1'b1; bk_rdata = 32'hFFFFFFFF; cyc();
        bk_ack = 1'b0; bk_rdata = '0; repeat (2) cyc();
        check("t7_req_cycles", req_cycles, 16);
        check("t7_ready_low", ready_low, 17);
        check("t7_serr", serr_cycles, 2);
        check("t7_err_cnt", err_cnt, 8'd4);

        // Reset in the middle of ACCESS, then a clean transfer
        addr_ph(32'h3000, 1'b1, 3'd2); cyc();
        bus_idle(); #2;
        check("t8_req_before", bk_req, 1'b1);
        rstn = 1'b0; #1;
        check("t8_req_async", bk_req, 1'b0);
        check("t8_ready_async", ready, 1'b1);
        check("t8_err_cnt", err_cnt, 8'd0);
        cyc();
        rstn = 1'b1; cyc();
        clr_mon();
        addr_ph(32'h3004, 1'b1, 3'd2); cyc();
        bus_idle(); wdata = 32'h55; bk_ack = 1'b1; cyc();
        bk_ack = 1'b0; cyc();
        check("t8_req_cycles", req_cycles, 1);
        check("t8_serr", serr_cycles, 0);
        check("t8_addr", addr_log[0], 32'h3004);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
